// File: rtl/control_unit_if.sv
// Control unit bus: instruction fetch, data memory and register-file control.
interface control_unit_if;
  logic        Run;
  logic [15:0] InstrData;
  logic [6:0]  PC_addr;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s;
  logic        Halted;

  modport master (
    input  Run, InstrData,
    output PC_addr, D_addr, D_wr, RF_s,
    output RF_W_en, RF_W_addr, RF_Ra_addr,
    output RF_Rb_addr, ALU_s, Halted
  );

  modport slave (
    output Run, InstrData,
    input  PC_addr, D_addr, D_wr, RF_s,
    input  RF_W_en, RF_W_addr, RF_Ra_addr,
    input  RF_Rb_addr, ALU_s, Halted
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle Moore control unit; CTRL_ILLEGAL_OP_EN halts on bad opcodes.
module control_unit (
  input  logic Clock,
  input  logic ResetN,
`ifdef CTRL_ILLEGAL_OP_EN
  output logic IllegalOp,
`endif
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, NOOP, LOAD_A,
    LOAD_B, STORE, ADD, SUB, HALT
  } state_t;

  state_t      state, nstate;
  logic [6:0]  pc;
  logic [15:0] ir;
  logic [3:0]  op;

  assign op = ir[15:12];

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= nstate;
      if (state == FETCH) begin
        ir <= bus.InstrData;
        pc <= pc + 7'd1;
      end
    end
  end

`ifdef CTRL_ILLEGAL_OP_EN
  logic ill_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)
      ill_q <= 1'b0;
    else if (state == DECODE && op > 4'd5)
      ill_q <= 1'b1;
  end

  assign IllegalOp = ill_q;
`endif

  always_comb begin
    nstate = state;
    unique case (state)
      INIT:   nstate = bus.Run ? FETCH : INIT;
      FETCH:  nstate = DECODE;
      DECODE: begin
        case (op)
          4'h0:    nstate = NOOP;
          4'h1:    nstate = STORE;
          4'h2:    nstate = LOAD_A;
          4'h3:    nstate = ADD;
          4'h4:    nstate = SUB;
          4'h5:    nstate = HALT;
`ifdef CTRL_ILLEGAL_OP_EN
          default: nstate = HALT;
`else
          default: nstate = NOOP;
`endif
        endcase
      end
      NOOP:   nstate = FETCH;
      LOAD_A: nstate = LOAD_B;
      LOAD_B: nstate = FETCH;
      STORE:  nstate = FETCH;
      ADD:    nstate = FETCH;
      SUB:    nstate = FETCH;
      HALT:   nstate = HALT;
      default: nstate = INIT;
    endcase
  end

  assign bus.PC_addr = pc;

  // Outputs depend only on state and IR, so reset clears them at once.
  always_comb begin
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.ALU_s      = 3'b000;
    bus.Halted     = 1'b0;
    unique case (1'b1)
      (state == LOAD_A): begin
        bus.D_addr = ir[11:4];
      end
      (state == LOAD_B): begin
        bus.D_addr    = ir[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_en   = 1'b1;
        bus.RF_W_addr = ir[3:0];
      end
      (state == STORE): begin
        bus.RF_Ra_addr = ir[11:8];
        bus.D_addr     = ir[7:0];
        bus.D_wr       = 1'b1;
      end
      (state == ADD),
      (state == SUB): begin
        bus.RF_Ra_addr = ir[11:8];
        bus.RF_Rb_addr = ir[7:4];
        bus.RF_W_addr  = ir[3:0];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s      = (state == ADD) ? 3'b001
                                        : 3'b010;
      end
      (state == HALT): begin
        bus.Halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode, timing, halt, wrap and reset.
module tb_control_unit;

  logic Clock = 1'b0;
  logic ResetN;
  int   checks = 0;
  int   errors = 0;
  int   bad;

  control_unit_if bus ();

`ifdef CTRL_ILLEGAL_OP_EN
  logic IllegalOp;
  control_unit dut (
    .Clock(Clock), .ResetN(ResetN),
    .IllegalOp(IllegalOp), .bus(bus)
  );
`else
  control_unit dut (
    .Clock(Clock), .ResetN(ResetN), .bus(bus)
  );
`endif

  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [15:0] en();
    return {12'd0, bus.D_wr, bus.RF_W_en,
            bus.RF_s, bus.Halted};
  endfunction

  function automatic logic [15:0] regs();
    return {bus.RF_Ra_addr, bus.RF_Rb_addr,
            bus.RF_W_addr, 1'b0, bus.ALU_s};
  endfunction

  initial begin
    bus.Run = 1'b0;
    bus.InstrData = 16'h0000;
    ResetN = 1'b0;
    #12;
    check("rst_pc", 16'(bus.PC_addr), 16'd0);
    check("rst_en", en(), 16'h0);
    check("rst_daddr", 16'(bus.D_addr), 16'h0);
    ResetN = 1'b1;
    tick();
    tick();
    check("init_hold_pc", 16'(bus.PC_addr), 16'd0);
    bus.Run = 1'b1;
    tick();
    bus.Run = 1'b0;

    for (int k = 1; k <= 3; k++) begin
      tick();
      check("noop_pc", 16'(bus.PC_addr), 16'(k));
      check("noop_dec_en", en(), 16'h0);
      tick();
      check("noop_en", en(), 16'h0);
      tick();
      check("noop_fetch_en", en(), 16'h0);
    end

    bus.InstrData = 16'h2A53;
    tick();
    check("load_pc", 16'(bus.PC_addr), 16'd4);
    tick();
    check("loada_daddr", 16'(bus.D_addr), 16'h00A5);
    check("loada_en", en(), 16'h0);
    tick();
    check("loadb_daddr", 16'(bus.D_addr), 16'h00A5);
    check("loadb_en", en(), 16'h6);
    check("loadb_wa", 16'(bus.RF_W_addr), 16'h3);
    tick();
    check("load_done_en", en(), 16'h0);

    bus.InstrData = 16'h1712;
    tick();
    tick();
    check("store_en", en(), 16'h8);
    check("store_daddr", 16'(bus.D_addr), 16'h0012);
    check("store_regs", regs(), 16'h7000);
    tick();
    check("store_once", en(), 16'h0);

    bus.InstrData = 16'h4129;
    tick();
    tick();
    check("sub_regs", regs(), 16'h1292);
    check("sub_en", en(), 16'h4);
    check("sub_daddr", 16'(bus.D_addr), 16'h0);
    tick();

    bus.InstrData = 16'h3456;
    tick();
    tick();
    check("add_regs", regs(), 16'h4561);
    check("add_en", en(), 16'h4);
    tick();
    check("add_done_en", en(), 16'h0);

    bus.InstrData = 16'hF000;
    tick();
    check("ill_pc", 16'(bus.PC_addr), 16'd8);
    tick();
`ifdef CTRL_ILLEGAL_OP_EN
    check("ill_halt", en(), 16'h1);
    check("ill_flag", 16'(IllegalOp), 16'h1);
`else
    check("ill_noop", en(), 16'h0);
    bus.InstrData = 16'h0000;
    tick();
    tick();
    check("ill_next_pc", 16'(bus.PC_addr), 16'd9);
`endif

    ResetN = 1'b0;
    #2;
    check("rst2_pc", 16'(bus.PC_addr), 16'd0);
    check("rst2_en", en(), 16'h0);
`ifdef CTRL_ILLEGAL_OP_EN
    check("rst2_ill", 16'(IllegalOp), 16'h0);
`endif
    ResetN = 1'b1;
    bus.InstrData = 16'h0000;
    bus.Run = 1'b1;
    tick();
    for (int k = 0; k < 127; k++) begin
      tick();
      tick();
      tick();
    end
    check("pc_127", 16'(bus.PC_addr), 16'd127);
    bus.InstrData = 16'h5000;
    tick();
    check("pc_wrap", 16'(bus.PC_addr), 16'd0);
    tick();
    check("halt_en", en(), 16'h1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.Run = i[0];
      tick();
      if (en() !== 16'h1 || bus.PC_addr !== 7'd0)
        bad++;
    end
    check("halt_hold", 16'(bad), 16'd0);

    ResetN = 1'b0;
    #2;
    ResetN = 1'b1;
    bus.Run = 1'b1;
    tick();
    bus.InstrData = 16'h2A53;
    tick();
    tick();
    check("mid_loada", 16'(bus.D_addr), 16'h00A5);
    ResetN = 1'b0;
    #1;
    check("mid_rst_daddr", 16'(bus.D_addr), 16'h0);
    check("mid_rst_pc", 16'(bus.PC_addr), 16'd0);
    check("mid_rst_en", en(), 16'h0);
    #1;
    ResetN = 1'b1;
    bus.Run = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (en() !== 16'h0 || bus.PC_addr !== 7'd0)
        bad++;
    end
    check("post_rst_wait", 16'(bad), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports Clock and ResetN.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 ResetN  input  1  asynchronous active-low reset.
REQ-004 Run  input  1  start request; sampled only in INIT.
REQ-005 InstrData  input  16  instruction word at PC_addr, combinational read.
REQ-006 PC_addr  output  7  program counter.
REQ-007 D_addr  output  8  data-memory address.
REQ-008 D_wr  output  1  data-memory write enable.
REQ-009 RF_s  output  1  register-file write-data select: 1 = memory data, 0 = ALU result.
REQ-010 RF_W_en, RF_W_addr[3:0], RF_Ra_addr[3:0], RF_Rb_addr[3:0]  output  register-file write enable and port addresses.
REQ-011 ALU_s  output  3  ALU operation: 000 pass-A, 001 add, 010 sub.
REQ-012 Halted  output  1  high while in HALT.
REQ-013 IllegalOp  output  1  sticky illegal-opcode flag; present only with CTRL_ILLEGAL_OP_EN.

Function
REQ-014 The FSM SHALL have states INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB and HALT, with registered state and Moore outputs.
REQ-015 Opcode decode SHALL be IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT.
REQ-016 Field decode SHALL be:
- LOAD: D_addr = IR[11:4], Rd = IR[3:0].
- STORE: Ra = IR[11:8], D_addr = IR[7:0].
- ADD/SUB: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0].
REQ-017 INIT SHALL move to FETCH when Run = 1 and hold otherwise.
REQ-018 FETCH SHALL capture IR <= InstrData and PC <= PC+1, with 7-bit wrap 127 -> 0, then move to DECODE.
REQ-019 DECODE SHALL drive no write enables and SHALL branch to the state selected by the opcode.
REQ-020 NOOP SHALL assert no enables and return to FETCH.
REQ-021 LOAD_A SHALL drive D_addr and move to LOAD_B.
REQ-022 LOAD_B SHALL hold D_addr and assert RF_s = 1, RF_W_en = 1, RF_W_addr = Rd, then return to FETCH.
REQ-023 STORE SHALL drive RF_Ra_addr = Ra, D_addr, ALU_s = 000 and D_wr = 1 for exactly one cycle, then return to FETCH.
REQ-024 ADD SHALL drive Ra, Rb, ALU_s = 001, RF_s = 0, RF_W_en = 1 and RF_W_addr = Rd for one cycle, then return to FETCH.
REQ-025 SUB SHALL behave as ADD with ALU_s = 010.
REQ-026 HALT SHALL assert Halted, keep all enables low, and hold until ResetN; Run SHALL be ignored.
REQ-027 Instruction latency SHALL be 3 cycles (FETCH, DECODE, execute), or 4 cycles for LOAD.
REQ-028 D_wr and RF_W_en SHALL never both be high, and SHALL never be high outside STORE, LOAD_B, ADD and SUB.
REQ-029 Unused address outputs SHALL be driven to 0 in every state.

Reset
REQ-030 ResetN low SHALL immediately force INIT, PC = 0, IR = 0, all outputs 0 and IllegalOp = 0, including mid-instruction.
REQ-031 After ResetN deasserts, the first fetch SHALL wait for Run = 1.

Configuration
REQ-032 With CTRL_ILLEGAL_OP_EN defined, opcodes 0110-1111 SHALL go from DECODE to HALT and set IllegalOp until reset.
REQ-033 Without CTRL_ILLEGAL_OP_EN, opcodes 0110-1111 SHALL execute as NOOP and the IllegalOp port SHALL not exist.

Verification
REQ-034 Reset then Run = 1, InstrData = 0x0000 -> FETCH/DECODE/NOOP cycle repeats, PC = 1, 2, 3, and no enables ever assert.
REQ-035 InstrData = 0x2A53 (LOAD) -> LOAD_A then LOAD_B with D_addr = 0xA5, RF_s = 1, RF_W_en = 1, RF_W_addr = 3.
REQ-036 InstrData = 0x1712 (STORE) -> one cycle of D_wr = 1, D_addr = 0x12, RF_Ra_addr = 7; then InstrData = 0x4129 (SUB) -> ALU_s = 010, Ra = 1, Rb = 2, Rd = 9, RF_W_en = 1.
REQ-037 InstrData = 0x5000 (HALT) -> Halted = 1 and state stays HALT for 20 cycles with Run toggling.
REQ-038 InstrData = 0xF000 -> with CTRL_ILLEGAL_OP_EN, HALT with IllegalOp = 1; without it, NOOP behaviour.
REQ-039 PC at 127 -> wraps to 0 after FETCH; ResetN pulsed low during LOAD_A -> RF_W_en never asserts and outputs clear at once.
